pow_gen: RTL

//   Iterative generator of BASE**exp, truncated to WIDTH bits, with a

---
 rtl/pow_gen.sv | 92 +++++++++
 1 files changed

// File: rtl/pow_gen.sv
// Iterative BASE**exp generator, truncated to WIDTH bits, with a sticky overflow flag.
// One request at a time, with a valid/ready handshake on both the request and result sides.
//
// state | meaning
// IDLE  | waiting for a request; in_ready=1
// MUL   | multiplying acc by BASE, rem counts down to zero
// HOLD  | result presented; waits for out_ready
module pow_gen #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 5,
  parameter int BASE  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  localparam logic [2*WIDTH-1:0] PROD_BASE = (2*WIDTH)'(BASE);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [EXP_W-1:0]   rem, rem_nxt;
  logic [EXP_W-1:0]   exp_q, exp_nxt;
  logic               ovf, ovf_nxt;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      rem   <= '0;
      exp_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      exp_q <= exp_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    exp_nxt   = exp_q;
    ovf_nxt   = ovf;
    // full-width product so the bits that fall off the top can be detected
    prod      = {{WIDTH{1'b0}}, acc} * PROD_BASE;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          rem_nxt   = in_exp;
          exp_nxt   = in_exp;
          acc_nxt   = WIDTH'(1);
          ovf_nxt   = 1'b0;
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (rem == '0) begin
          state_nxt = S_HOLD;
        end else begin
          acc_nxt = prod[WIDTH-1:0];
          ovf_nxt = ovf | (|prod[2*WIDTH-1:WIDTH]);
          rem_nxt = rem - EXP_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);
  assign out_num   = acc;
  assign out_exp   = exp_q;
  assign out_ovf   = ovf;

endmodule
